ipsl_pcie_apb2dbi_v2_0: RTL and testbench

//  Parametrised APB-to-DBI bridge for PCIe controller config space. It sits between the

---
 rtl/ipsl_pcie_apb2dbi_v2_0.sv | 205 ++++++++++++++++++++
 tb/tb_ipsl_pcie_apb2dbi_v2_0.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipsl_pcie_apb2dbi_v2_0.sv
// APB (pclk_div2) to PCIe controller LBC/DBI config-space bridge with ack timeout and slverr.
// Latency: access sampled T0, dbi_cs at T1, ack sampled Tk, p_rdy at Tk+2 (posted writes: p_rdy at T2).
// Backpressure: one access in flight; dbi_halt stalls completion; PCIE_APB2DBI_WPOST_EN enables write posting.
`timescale 1ns/1ps

module ipsl_pcie_apb2dbi_v2_0 #(
  parameter int unsigned      ADDR_W   = 16,
  parameter int unsigned      DBI_AW   = 12,
  parameter int unsigned      TO_W     = 8,
  parameter logic [TO_W-1:0]  TO_LIMIT = 8'd200,
  parameter logic [31:0]      ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic              pclk_div2,
  input  logic              apb_rst_n,
  // APB config port
  input  logic              p_sel,
  input  logic              p_ce,
  input  logic              p_we,
  input  logic [3:0]        p_strb,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [31:0]       p_wdata,
  output logic              p_rdy,
  output logic [31:0]       p_rdata,
  output logic              p_slverr,
  // controller LBC/DBI side
  output logic [31:0]       dbi_addr,
  output logic [31:0]       dbi_din,
  output logic              dbi_cs,
  output logic              dbi_cs2,
  output logic [3:0]        dbi_wr,
  output logic              app_dbi_ro_wr_disable,
  input  logic              lbc_dbi_ack,
  input  logic [31:0]       lbc_dbi_dout,
  input  logic              dbi_halt,
  output logic              post_err
);

`ifdef PCIE_APB2DBI_WPOST_EN
  localparam bit WPOST_EN = 1'b1;
`else
  localparam bit WPOST_EN = 1'b0;
`endif

  // WPOST: a write already completed on APB, still waiting for the DBI ack.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_RESP  = 2'd2,
    S_WPOST = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [TO_W-1:0]    r_cnt;
  logic               r_we;
  logic               r_err;
  logic [31:0]        r_rdbuf;

  logic               w_apb_held;
  logic               w_apb_access;
  logic               w_busy;
  logic [TO_W-1:0]    w_cnt_inc;
  logic               w_to_hit;
  logic               w_done;
  logic               w_timeout;
  logic               w_first;
  logic               w_load;
  logic               w_rdy_set;
  logic [31:0]        w_dbi_addr;

  // Address bits above the DBI span carry no meaning for config space.
  generate
    if (ADDR_W > DBI_AW) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^p_addr[ADDR_W-1:DBI_AW];
    end
  endgenerate

  assign w_apb_held   = p_sel & p_ce;
  // The p_rdy cycle itself must not be taken as a fresh access.
  assign w_apb_access = w_apb_held & ~p_rdy;
  assign w_busy       = (r_state == S_WAIT) || (r_state == S_WPOST);
  assign w_cnt_inc    = r_cnt + {{(TO_W-1){1'b0}}, 1'b1};
  // Fires on the TO_LIMIT-th DBI wait cycle without an ack.
  assign w_to_hit     = (w_cnt_inc == TO_LIMIT);
  // Ack wins over a simultaneous timeout.
  assign w_done       = w_busy & (lbc_dbi_ack | w_to_hit);
  assign w_timeout    = w_busy & ~lbc_dbi_ack & w_to_hit;
  assign w_first      = (r_cnt == {TO_W{1'b0}});
  assign w_dbi_addr   = {{(32-DBI_AW){1'b0}}, p_addr[DBI_AW-1:2], 2'b00};

  // State register.
  always_ff @(posedge pclk_div2 or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle strobes: access launch and APB completion.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_rdy_set   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_apb_access) begin
          w_load      = 1'b1;
          w_state_nxt = (WPOST_EN && p_we) ? S_WPOST : S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_done) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        // A master that dropped sel/ce here has aborted: finish silently.
        if (!dbi_halt) begin
          w_state_nxt = S_IDLE;
          w_rdy_set   = w_apb_held;
        end
      end
      S_WPOST: begin
        // The posted write completes on APB in its first cycle, then waits out the DBI.
        w_rdy_set = w_first & w_apb_held;
        if (w_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // DBI drive, timeout counter, read capture and APB response registers.
  always_ff @(posedge pclk_div2 or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      dbi_addr              <= 32'd0;
      dbi_din               <= 32'd0;
      dbi_cs                <= 1'b0;
      dbi_cs2               <= 1'b0;
      dbi_wr                <= 4'd0;
      app_dbi_ro_wr_disable <= 1'b0;
      p_rdy                 <= 1'b0;
      p_rdata               <= 32'd0;
      p_slverr              <= 1'b0;
      r_cnt                 <= {TO_W{1'b0}};
      r_we                  <= 1'b0;
      r_err                 <= 1'b0;
      r_rdbuf               <= 32'd0;
    end else begin
      dbi_wr   <= 4'd0;
      p_rdy    <= w_rdy_set;
      p_slverr <= w_rdy_set & (r_state == S_RESP) & r_err;
      // Read data reaches p_rdata only when the completion is actually issued.
      if (w_rdy_set && (r_state == S_RESP) && !r_we) begin
        p_rdata <= r_rdbuf;
      end
      if (w_load) begin
        dbi_cs                <= 1'b1;
        dbi_cs2               <= p_addr[0];
        app_dbi_ro_wr_disable <= p_addr[1];
        dbi_addr              <= w_dbi_addr;
        dbi_din               <= p_wdata;
        dbi_wr                <= p_we ? p_strb : 4'd0;
        r_we                  <= p_we;
        r_cnt                 <= {TO_W{1'b0}};
        r_err                 <= 1'b0;
      end else if (w_done) begin
        dbi_cs                <= 1'b0;
        dbi_cs2               <= 1'b0;
        app_dbi_ro_wr_disable <= 1'b0;
        r_cnt                 <= w_cnt_inc;
        r_err                 <= w_timeout;
        if (!r_we) begin
          r_rdbuf <= lbc_dbi_ack ? lbc_dbi_dout : ERR_DATA;
        end
      end else if (w_busy) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

`ifdef PCIE_APB2DBI_WPOST_EN
  logic r_post_err;

  // Sticky record of a posted write that never got its DBI ack.
  always_ff @(posedge pclk_div2 or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      r_post_err <= 1'b0;
    end else if (w_timeout && (r_state == S_WPOST)) begin
      r_post_err <= 1'b1;
    end
  end

  assign post_err = r_post_err;
`else
  assign post_err = 1'b0;
`endif

endmodule

// File: tb/tb_ipsl_pcie_apb2dbi_v2_0.sv
`timescale 1ns/1ps

module tb_ipsl_pcie_apb2dbi_v2_0;

`ifdef PCIE_APB2DBI_WPOST_EN
  localparam bit WPOST = 1'b1;
`else
  localparam bit WPOST = 1'b0;
`endif
  localparam int LIM = 200;

  logic        pclk_div2 = 1'b0;
  logic        apb_rst_n = 1'b0;
  logic        p_sel = 1'b0, p_ce = 1'b0, p_we = 1'b0;
  logic [3:0]  p_strb = 4'd0;
  logic [15:0] p_addr = 16'd0;
  logic [31:0] p_wdata = 32'd0;
  logic        p_rdy, p_slverr;
  logic [31:0] p_rdata;
  logic [31:0] dbi_addr, dbi_din;
  logic        dbi_cs, dbi_cs2, app_dbi_ro_wr_disable, post_err;
  logic [3:0]  dbi_wr;
  logic        lbc_dbi_ack = 1'b0;
  logic [31:0] lbc_dbi_dout = 32'd0;
  logic        dbi_halt = 1'b0;

  ipsl_pcie_apb2dbi_v2_0 dut (
    .pclk_div2(pclk_div2), .apb_rst_n(apb_rst_n),
    .p_sel(p_sel), .p_ce(p_ce), .p_we(p_we), .p_strb(p_strb), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdy(p_rdy), .p_rdata(p_rdata), .p_slverr(p_slverr),
    .dbi_addr(dbi_addr), .dbi_din(dbi_din), .dbi_cs(dbi_cs), .dbi_cs2(dbi_cs2), .dbi_wr(dbi_wr),
    .app_dbi_ro_wr_disable(app_dbi_ro_wr_disable),
    .lbc_dbi_ack(lbc_dbi_ack), .lbc_dbi_dout(lbc_dbi_dout), .dbi_halt(dbi_halt),
    .post_err(post_err)
  );

  always #5 pclk_div2 = ~pclk_div2;

  int cyc = 0;
  always @(posedge pclk_div2) cyc <= cyc + 1;

  typedef struct { logic [31:0] rdata; logic slverr; int cyc; } rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] din; logic cs2; logic ro; logic [3:0] wr; int len; } dbi_t;

  rsp_t        rsp_q[$];
  dbi_t        dbi_q[$];
  dbi_t        cur;
  dbi_t        tmp;
  int          cs_len = 0;
  bit          prev_cs = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents p_rdy or starts a DBI access.
  always @(negedge pclk_div2) begin
    if (!apb_rst_n) begin
      chk("rst_ctrl", {24'd0, p_rdy, p_slverr, dbi_cs, dbi_cs2, dbi_wr}, 32'd0);
      chk("rst_misc", {30'd0, app_dbi_ro_wr_disable, post_err}, 32'd0);
      chk("rst_rdata", p_rdata, 32'd0);
      chk("rst_dbi_addr", dbi_addr, 32'd0);
      chk("rst_dbi_din", dbi_din, 32'd0);
      prev_cs = 1'b0;
    end else begin
      if (p_rdy) begin
        if (rsp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_p_rdy: got p_rdy=1, want 0 (cycle %0d)", cyc);
        end else begin
          rsp_t e;
          e = rsp_q.pop_front();
          chk("rdy_cycle", cyc, e.cyc);
          chk("rdata", p_rdata, e.rdata);
          chk("slverr", {31'd0, p_slverr}, {31'd0, e.slverr});
        end
      end else begin
        chk("slverr_without_rdy", {31'd0, p_slverr}, 32'd0);
      end
      if (dbi_cs && !prev_cs) begin
        if (dbi_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_dbi_cs: got dbi_cs=1, want 0 (cycle %0d)", cyc);
        end else begin
          cur = dbi_q.pop_front();
          chk("dbi_addr", dbi_addr, cur.addr);
          chk("dbi_din", dbi_din, cur.din);
          chk("cs2_ro", {30'd0, dbi_cs2, app_dbi_ro_wr_disable}, {30'd0, cur.cs2, cur.ro});
          chk("dbi_wr", {28'd0, dbi_wr}, {28'd0, cur.wr});
        end
        cs_len = 1;
      end else if (dbi_cs) begin
        cs_len++;
        chk("wr_one_cycle", {28'd0, dbi_wr}, 32'd0);
        chk("hold_cs2_ro", {30'd0, dbi_cs2, app_dbi_ro_wr_disable}, {30'd0, cur.cs2, cur.ro});
        chk("hold_addr", dbi_addr, cur.addr);
        chk("hold_din", dbi_din, cur.din);
      end else begin
        chk("wr_idle", {28'd0, dbi_wr}, 32'd0);
        if (prev_cs) begin
          chk("cs_length", cs_len, cur.len);
          chk("cs2_ro_dropped", {30'd0, dbi_cs2, app_dbi_ro_wr_disable}, 32'd0);
        end
      end
      prev_cs = dbi_cs;
    end
  end

  // One APB access. ack_at: ack cycle relative to the accepted T0 (0 = never ack).
  // stall: cycles between driving and acceptance. late_ack: stray ack this many cycles after cs ends.
  task automatic access(input logic [15:0] addr, input logic we, input logic [3:0] strb,
                        input logic [31:0] wdata, input int ack_at, input logic [31:0] dout,
                        input int halt_n, input bit abort, input int stall, input int late_ack);
    int   t0, tend;
    bit   posted, got;
    rsp_t r;
    dbi_t d;
    posted = WPOST && we;
    t0     = cyc + stall;
    d.addr = {20'd0, addr[11:2], 2'b00};
    d.din  = wdata;
    d.cs2  = addr[0];
    d.ro   = addr[1];
    d.wr   = we ? strb : 4'h0;
    d.len  = (ack_at > 0) ? ack_at : LIM;
    dbi_q.push_back(d);
    tend = t0 + d.len;
    if (!abort) begin
      if (!we) m_rdata = (ack_at > 0) ? dout : 32'hDEAD_BEEF;
      r.rdata  = m_rdata;
      r.slverr = posted ? 1'b0 : (ack_at == 0);
      r.cyc    = posted ? t0 + 2 : tend + halt_n + 2;
      rsp_q.push_back(r);
    end
    p_sel = 1'b1; p_ce = 1'b1; p_we = we; p_strb = strb; p_addr = addr; p_wdata = wdata;
    fork
      begin
        if (ack_at > 0) begin
          while (cyc < t0 + ack_at) begin @(posedge pclk_div2); #1; end
          lbc_dbi_ack = 1'b1; lbc_dbi_dout = dout; dbi_halt = (halt_n > 0);
          @(posedge pclk_div2); #1;
          lbc_dbi_ack = 1'b0;
          repeat (halt_n) begin @(posedge pclk_div2); #1; end
          dbi_halt = 1'b0;
        end
        if (late_ack > 0) begin
          while (cyc < tend + late_ack) begin @(posedge pclk_div2); #1; end
          lbc_dbi_ack = 1'b1; lbc_dbi_dout = 32'hBAAD_0ACC;
          @(posedge pclk_div2); #1;
          lbc_dbi_ack = 1'b0;
          repeat (3) begin @(posedge pclk_div2); #1; end
        end
      end
      begin
        if (abort) begin
          while (cyc < t0 + 2) begin @(posedge pclk_div2); #1; end
          p_sel = 1'b0; p_ce = 1'b0;
          repeat (ack_at + 4) @(posedge pclk_div2);
          #1;
        end else begin
          got = 1'b0;
          for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge pclk_div2);
            if (p_rdy) got = 1'b1;
          end
          if (!got) begin
            n_vec++; n_err++;
            $display("FAIL rdy_wait: got no p_rdy within 1000 cycles, want p_rdy at cycle %0d", r.cyc);
          end
          @(posedge pclk_div2); #1;
          p_sel = 1'b0; p_ce = 1'b0;
        end
      end
    join
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge pclk_div2);
    #1 apb_rst_n = 1'b1;
    @(posedge pclk_div2); #1;

    // read, ack at T4 -> p_rdy T6
    access(16'h0010, 1'b0, 4'h0, 32'h0, 4, 32'h1234_5678, 0, 1'b0, 0, 0);
    // write to CS2 space with RO-write override, strobes C
    access(16'h0007, 1'b1, 4'hC, 32'hA5A5_0000, 3, 32'h0, 0, 1'b0, 0, 0);
    // read with strobes set, top dword of the span, high address bits ignored, ack on first WAIT cycle
    access(16'hFFFC, 1'b0, 4'hF, 32'h0, 1, 32'h0BAD_F00D, 0, 1'b0, 0, 0);
    // read timeout with a late stray ack
    access(16'h0020, 1'b0, 4'h0, 32'h0, 0, 32'h0, 0, 1'b0, 0, 5);
    chk("late_ack_ignored", {30'd0, dbi_cs, p_rdy}, 32'd0);
    // ack on the timeout cycle wins
    access(16'h0050, 1'b0, 4'h0, 32'h0, LIM, 32'h55AA_55AA, 0, 1'b0, 0, 0);
    // halt 10 cycles after ack
    access(16'h0030, 1'b0, 4'h0, 32'h0, 2, 32'hCAFE_0001, 10, 1'b0, 0, 0);
    // master abort, then the next access is accepted
    access(16'h0040, 1'b0, 4'h0, 32'h0, 4, 32'h1111_2222, 0, 1'b1, 0, 0);
    access(16'h0044, 1'b0, 4'h0, 32'h0, 2, 32'h3333_4444, 0, 1'b0, 0, 0);
    // write that never gets an ack
    access(16'h0008, 1'b1, 4'hF, 32'h0102_0304, 0, 32'h0, 0, 1'b0, 0, 0);
`ifdef PCIE_APB2DBI_WPOST_EN
    repeat (LIM + 5) @(posedge pclk_div2);
    #1;
    chk("post_err_set", {31'd0, post_err}, 32'd1);
`else
    chk("post_err_tied", {31'd0, post_err}, 32'd0);
`endif

    // reset in the middle of an access
    tmp.addr = 32'h60; tmp.din = 32'h0; tmp.cs2 = 1'b1; tmp.ro = 1'b1; tmp.wr = 4'h0; tmp.len = 0;
    dbi_q.push_back(tmp);
    p_sel = 1'b1; p_ce = 1'b1; p_we = 1'b0; p_strb = 4'h0; p_addr = 16'h0063; p_wdata = 32'h0;
    repeat (3) begin @(posedge pclk_div2); #1; end
    #1 apb_rst_n = 1'b0;
    #1 chk("rst_mid_clear", {29'd0, dbi_cs, dbi_cs2, app_dbi_ro_wr_disable}, 32'd0);
    p_sel = 1'b0; p_ce = 1'b0;
    m_rdata = 32'd0;
    repeat (2) @(posedge pclk_div2);
    #1 apb_rst_n = 1'b1;
    @(posedge pclk_div2); #1 lbc_dbi_ack = 1'b1;
    @(posedge pclk_div2); #1 lbc_dbi_ack = 1'b0;
    repeat (3) begin @(posedge pclk_div2); #1; end
    chk("stray_ack_after_reset", {30'd0, dbi_cs, p_rdy}, 32'd0);
    access(16'h0064, 1'b0, 4'h0, 32'h0, 3, 32'h7777_8888, 0, 1'b0, 0, 0);

`ifdef PCIE_APB2DBI_WPOST_EN
    // posted write then back-to-back read: read accepted only after the write ack
    fork
      access(16'h000C, 1'b1, 4'h3, 32'h0000_BEEF, 5, 32'h0, 0, 1'b0, 0, 0);
      begin
        repeat (4) @(posedge pclk_div2);
        #2;
        access(16'h0070, 1'b0, 4'h0, 32'h0, 2, 32'h9999_AAAA, 0, 1'b0, 2, 0);
      end
    join
`else
    access(16'h000C, 1'b1, 4'h3, 32'h0000_BEEF, 5, 32'h0, 0, 1'b0, 0, 0);
    access(16'h0070, 1'b0, 4'h0, 32'h0, 2, 32'h9999_AAAA, 0, 1'b0, 0, 0);
`endif

    repeat (5) @(posedge pclk_div2);
    #1;
    chk("rsp_q_drained", rsp_q.size(), 32'd0);
    chk("dbi_q_drained", dbi_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
